// File: rtl/decode_if.sv
// Bundle of IF/ID, WB, EX/MEM inputs and the hazard/redirect/ID-EX outputs of the decode stage.
interface decode_if;
    logic [31:0] pc_plus4;
    logic [31:0] instrucao;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;

    logic [31:0] pc_branch_value;
    logic        mux_sel;
    logic        load_pc;
    logic        load_if_id_register;
    logic        if_flush;
    logic [31:0] id_ex_pc;
    logic [31:0] id_ex_rs1_data;
    logic [31:0] id_ex_rs2_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs1;
    logic [4:0]  id_ex_rs2;
    logic [4:0]  id_ex_rd;
    logic        id_ex_reg_write;
    logic        id_ex_mem_read;
    logic        id_ex_mem_write;
    logic        id_ex_mem_to_reg;
    logic        id_ex_alu_src;
    logic [1:0]  id_ex_alu_op;
    logic [3:0]  id_ex_funct;

    modport master (
        output pc_plus4, instrucao, wb_reg_write, wb_rd, wb_data,
               mem_reg_write, mem_mem_read, mem_rd, mem_alu_result,
        input  pc_branch_value, mux_sel, load_pc, load_if_id_register, if_flush,
               id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
               id_ex_alu_src, id_ex_alu_op, id_ex_funct
    );

    modport slave (
        input  pc_plus4, instrucao, wb_reg_write, wb_rd, wb_data,
               mem_reg_write, mem_mem_read, mem_rd, mem_alu_result,
        output pc_branch_value, mux_sel, load_pc, load_if_id_register, if_flush,
               id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
               id_ex_alu_src, id_ex_alu_op, id_ex_funct
    );
endinterface

// File: rtl/decode.sv
// RV32I-subset decode stage: register file, hazard detection, branch resolution in ID, ID/EX register.
// Optional macro ID_BRANCH_FWD_EN forwards mem_alu_result into the branch comparator.
module decode #(
    parameter logic [31:0] RESET_PC_OFFSET = 32'd4
) (
    input logic     clock,
    input logic     reset,
    decode_if.slave bus
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
        logic [3:0]  funct;
    } idex_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b;

    assign instr  = bus.instrucao;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

    ctrl_t       ctrl;
    logic [31:0] imm;
    logic        uses_rs2;
    logic        is_branch;

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        ctrl      = '0;
        imm       = '0;
        uses_rs2  = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_R:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = 2'b10; uses_rs2 = 1'b1; end
            OP_I:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = 2'b10; imm = imm_i; end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                imm             = imm_i;
            end
            OP_SW: begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; imm = imm_s; uses_rs2 = 1'b1; end
            OP_BR: begin ctrl.alu_op = 2'b01; imm = imm_b; uses_rs2 = 1'b1; is_branch = 1'b1; end
            default: ;
        endcase
    end

    logic [31:0] regs [32];

    // NOTE: the register file is reset as a whole because a cleared architectural state is required;
    // x0 is never written, so it stays zero after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (bus.wb_reg_write && bus.wb_rd != 5'd0) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    logic [31:0] rs1_data, rs2_data;
    assign rs1_data = (rs1 == 5'd0) ? '0 :
                      (bus.wb_reg_write && bus.wb_rd == rs1) ? bus.wb_data : regs[rs1];
    assign rs2_data = (rs2 == 5'd0) ? '0 :
                      (bus.wb_reg_write && bus.wb_rd == rs2) ? bus.wb_data : regs[rs2];

    idex_t idex_q, idex_d;

    // Without comparator forwarding, any pending EX/MEM write to a branch source must drain first.
    logic mem_busy;
    logic [31:0] cmp_a, cmp_b;
`ifdef ID_BRANCH_FWD_EN
    logic mem_fwd_ok;
    assign mem_busy   = bus.mem_mem_read;
    assign mem_fwd_ok = bus.mem_reg_write && !bus.mem_mem_read;
    assign cmp_a = (mem_fwd_ok && rs1 != 5'd0 && bus.mem_rd == rs1) ? bus.mem_alu_result : rs1_data;
    assign cmp_b = (mem_fwd_ok && rs2 != 5'd0 && bus.mem_rd == rs2) ? bus.mem_alu_result : rs2_data;
`else
    logic unused_alu_result;
    assign mem_busy          = bus.mem_mem_read || bus.mem_reg_write;
    assign cmp_a             = rs1_data;
    assign cmp_b             = rs2_data;
    assign unused_alu_result = ^bus.mem_alu_result;
`endif

    logic busy1, busy2, load_use, branch_stall, stall, taken;
    assign busy1 = rs1 != 5'd0 && ((idex_q.ctrl.reg_write && idex_q.rd == rs1) || (mem_busy && bus.mem_rd == rs1));
    assign busy2 = rs2 != 5'd0 && ((idex_q.ctrl.reg_write && idex_q.rd == rs2) || (mem_busy && bus.mem_rd == rs2));
    assign load_use = idex_q.ctrl.mem_read && idex_q.rd != 5'd0 &&
                      (idex_q.rd == rs1 || (uses_rs2 && idex_q.rd == rs2));
    assign branch_stall = is_branch && (busy1 || busy2);
    assign stall        = load_use || branch_stall;

    always_comb begin
        taken = 1'b0;
        if (is_branch) begin
            case (funct3)
                3'b000:  taken = (cmp_a == cmp_b);
                3'b001:  taken = (cmp_a != cmp_b);
                default: taken = 1'b0;
            endcase
        end
    end

    assign bus.load_pc             = !stall;
    assign bus.load_if_id_register = !stall;
    assign bus.mux_sel             = taken && !stall;
    assign bus.if_flush            = taken && !stall;
    assign bus.pc_branch_value     = bus.pc_plus4 - RESET_PC_OFFSET + imm_b;

    // A stalled instruction is replaced by an all-zero bubble.
    always_comb begin
        idex_d = '0;
        if (!stall) begin
            idex_d.pc       = bus.pc_plus4;
            idex_d.rs1_data = rs1_data;
            idex_d.rs2_data = rs2_data;
            idex_d.imm      = imm;
            idex_d.rs1      = rs1;
            idex_d.rs2      = rs2;
            idex_d.rd       = rd;
            idex_d.ctrl     = ctrl;
            idex_d.funct    = {instr[30], funct3};
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) idex_q <= '0;
        else        idex_q <= idex_d;
    end

    assign bus.id_ex_pc         = idex_q.pc;
    assign bus.id_ex_rs1_data   = idex_q.rs1_data;
    assign bus.id_ex_rs2_data   = idex_q.rs2_data;
    assign bus.id_ex_imm        = idex_q.imm;
    assign bus.id_ex_rs1        = idex_q.rs1;
    assign bus.id_ex_rs2        = idex_q.rs2;
    assign bus.id_ex_rd         = idex_q.rd;
    assign bus.id_ex_reg_write  = idex_q.ctrl.reg_write;
    assign bus.id_ex_mem_read   = idex_q.ctrl.mem_read;
    assign bus.id_ex_mem_write  = idex_q.ctrl.mem_write;
    assign bus.id_ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
    assign bus.id_ex_alu_src    = idex_q.ctrl.alu_src;
    assign bus.id_ex_alu_op     = idex_q.ctrl.alu_op;
    assign bus.id_ex_funct      = idex_q.funct;
endmodule
